wb_master_bridge: RTL and testbench

- Wishbone classic single-access initiator. It turns a simple valid/ready command into one Wishbone read or write cycle and returns a response.
- Drives the wb_bus slave interconnect from an internal requester, such as a DMA or test sequencer, in place of the management core.
- Has a watchdog timeout because the interconnect never acks unmapped addresses. A timeout ends the cycle and flags an error.

---
 rtl/wb_master_bridge.sv | 171 +++++++++++++++++
 tb/tb_wb_master_bridge.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_bridge.sv
// Wishbone classic single-access initiator: accepts one valid/ready command,
// runs a single read or write cycle on the bus, and returns a response.
// A watchdog aborts cycles the interconnect never acks and flags an error.
module wb_master_bridge #(
   parameter int unsigned TIMEOUT   = 16,
   parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_wdat,
   input  logic [3:0]  cmd_sel,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdat,
   output logic        rsp_err,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        busy,
   output logic [7:0]  err_count
);

   // Last watchdog value before the cycle is aborted.
   localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        busy_q, busy_d;
   logic        cyc_q, cyc_d;
   logic        stb_q, stb_d;
   logic        we_q, we_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [3:0]  sel_q, sel_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdat_q, rsp_rdat_d;
   logic        rsp_err_q, rsp_err_d;
   logic [7:0]  err_count_q, err_count_d;
   logic [7:0]  wdog_q, wdog_d;

   // Next-state and registered-output computation.
   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdat_d  = rsp_rdat_q;
      rsp_err_d   = rsp_err_q;
      err_count_d = err_count_q;
      wdog_d      = wdog_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               we_d    = cmd_we;
               adr_d   = cmd_adr;
               dat_d   = cmd_wdat;
               sel_d   = cmd_sel;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               wdog_d  = '0;
               state_d = BUS;
            end
         end
         BUS: begin
            // Ack takes priority over a timeout firing on the same edge.
            if (wbm_ack_i) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               rsp_rdat_d  = we_q ? '0 : wbm_dat_i;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (wdog_q == WDOG_LAST) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               rsp_rdat_d  = ERR_RDATA;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               if (err_count_q != 8'hFF) begin
                  err_count_d = err_count_q + 8'd1;
               end
               state_d     = RESP;
            end else begin
               wdog_d = wdog_q + 8'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // cmd_ready and busy are registered decodes of the next state.
      cmd_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= 4'h0;
         rsp_valid_q <= 1'b0;
         rsp_rdat_q  <= '0;
         rsp_err_q   <= 1'b0;
         err_count_q <= '0;
         wdog_q      <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdat_q  <= rsp_rdat_d;
         rsp_err_q   <= rsp_err_d;
         err_count_q <= err_count_d;
         wdog_q      <= wdog_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = stb_q;
   assign wbm_we_o  = we_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;
   assign wbm_sel_o = sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdat  = rsp_rdat_q;
   assign rsp_err   = rsp_err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: a vector table of single transactions
// plus hand-written sequences for late ack, backpressure, saturation and reset.
module tb_wb_master_bridge;

   logic        wb_clk;
   logic        wb_rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [31:0] cmd_adr;
   logic [31:0] cmd_wdat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdat;
   logic        rsp_err;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;
   logic        busy;
   logic [7:0]  err_count;

   int unsigned n_chk;
   int unsigned n_fail;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] wdat;
      logic [3:0]  sel;
      int unsigned ack_at;   // stb cycle in which the slave acks; 0 = never
      logic [31:0] ack_dat;
      logic [31:0] exp_rdat;
      logic        exp_err;
      int unsigned exp_stb;
      logic [7:0]  exp_ec;
   } vec_t;

   vec_t vecs [6];

   wb_master_bridge #(
      .TIMEOUT   (16),
      .ERR_RDATA (32'hDEAD_BEEF)
   ) dut (
      .wb_clk    (wb_clk),
      .wb_rst    (wb_rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_adr   (cmd_adr),
      .cmd_wdat  (cmd_wdat),
      .cmd_sel   (cmd_sel),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdat  (rsp_rdat),
      .rsp_err   (rsp_err),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_ack_i (wbm_ack_i),
      .busy      (busy),
      .err_count (err_count)
   );

   initial wb_clk = 1'b0;
   always #5 wb_clk = ~wb_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Issue one command, play the slave, and return at the negedge where
   // rsp_valid is first seen (response not yet accepted).
   task automatic issue_and_wait(input vec_t v);
      int unsigned stb_cnt;
      int unsigned lat;
      bit          done;
      stb_cnt = 0;
      lat     = 0;
      done    = 0;
      @(negedge wb_clk);
      cmd_we    = v.we;
      cmd_adr   = v.adr;
      cmd_wdat  = v.wdat;
      cmd_sel   = v.sel;
      cmd_valid = 1'b1;
      #1;
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      @(posedge wb_clk);
      #1 cmd_valid = 1'b0;
      for (int unsigned c = 0; c < 300 && !done; c++) begin
         @(negedge wb_clk);
         lat++;
         if (rsp_valid) begin
            done = 1;
         end else if (wbm_stb_o) begin
            stb_cnt++;
            chk("wbm_we", 32'(wbm_we_o), 32'(v.we));
            chk("wbm_adr", wbm_adr_o, v.adr);
            chk("wbm_dat", wbm_dat_o, v.wdat);
            chk("wbm_sel", 32'(wbm_sel_o), 32'(v.sel));
            wbm_ack_i = (v.ack_at != 0) && (stb_cnt == v.ack_at);
            wbm_dat_i = v.ack_dat;
         end else begin
            wbm_ack_i = 1'b0;
         end
      end
      wbm_ack_i = 1'b0;
      chk("rsp_arrived", 32'(done), 32'd1);
      chk("stb_cycles", stb_cnt, v.exp_stb);
      chk("rsp_latency", lat, v.exp_stb + 1);
      chk("cyc_dropped", 32'(wbm_cyc_o), 32'd0);
      chk("stb_dropped", 32'(wbm_stb_o), 32'd0);
      chk("cmd_ready_resp", 32'(cmd_ready), 32'd0);
      chk("busy_resp", 32'(busy), 32'd1);
   endtask

   // Accept the pending response and confirm the bridge is idle again.
   task automatic accept_rsp();
      rsp_ready = 1'b1;
      @(posedge wb_clk);
      #1 rsp_ready = 1'b0;
      @(negedge wb_clk);
      chk("rsp_valid_clr", 32'(rsp_valid), 32'd0);
      chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
      chk("busy_clr", 32'(busy), 32'd0);
   endtask

   initial begin
      vec_t        v;
      logic [31:0] held;
      logic [7:0]  exp_ec;

      n_chk  = 0;
      n_fail = 0;
      //          we    adr            wdat           sel   ack dat            rdat           err   stb ec
      vecs[0] = '{1'b1, 32'h3000_0004, 32'h0000_00A5, 4'hF, 1,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1,  8'd0};
      vecs[1] = '{1'b0, 32'h3002_0000, 32'h0000_0000, 4'hF, 3,  32'h1234_5678, 32'h1234_5678, 1'b0, 3,  8'd0};
      vecs[2] = '{1'b0, 32'h3100_0000, 32'h0000_0000, 4'hF, 0,  32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 16, 8'd1};
      vecs[3] = '{1'b0, 32'h3000_0010, 32'h0000_0000, 4'hF, 16, 32'h0000_0042, 32'h0000_0042, 1'b0, 16, 8'd1};
      vecs[4] = '{1'b0, 32'h3000_0020, 32'h5555_5555, 4'h3, 2,  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 2,  8'd1};
      vecs[5] = '{1'b1, 32'h3100_0100, 32'h0BAD_0BAD, 4'h1, 0,  32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 16, 8'd2};

      wb_rst    = 1'b1;
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_adr   = '0;
      cmd_wdat  = '0;
      cmd_sel   = '0;
      rsp_ready = 1'b0;
      wbm_dat_i = '0;
      wbm_ack_i = 1'b0;
      #2;
      chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
      chk("rst_stb", 32'(wbm_stb_o), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_adr", wbm_adr_o, 32'd0);
      chk("rst_sel", 32'(wbm_sel_o), 32'd0);
      chk("rst_rdat", rsp_rdat, 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      repeat (3) @(negedge wb_clk);
      wb_rst = 1'b0;

      for (int unsigned i = 0; i < 6; i++) begin
         issue_and_wait(vecs[i]);
         chk($sformatf("v%0d_rdat", i), rsp_rdat, vecs[i].exp_rdat);
         chk($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
         chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'(vecs[i].exp_ec));
         accept_rsp();
      end

      // Ack while idle must not start anything.
      @(negedge wb_clk);
      wbm_ack_i = 1'b1;
      wbm_dat_i = 32'h0000_0077;
      for (int unsigned i = 0; i < 3; i++) begin
         @(negedge wb_clk);
         chk("late_ack_busy", 32'(busy), 32'd0);
         chk("late_ack_rsp", 32'(rsp_valid), 32'd0);
      end
      wbm_ack_i = 1'b0;

      // Response backpressure with a second command waiting.
      v = '{1'b0, 32'h3000_0040, 32'h0, 4'hF, 2, 32'h1111_2222, 32'h1111_2222, 1'b0, 2, 8'd2};
      issue_and_wait(v);
      held      = rsp_rdat;
      chk("bp_rdat", held, 32'h1111_2222);
      cmd_we    = 1'b1;
      cmd_adr   = 32'h3000_0080;
      cmd_wdat  = 32'h0000_0099;
      cmd_sel   = 4'hC;
      cmd_valid = 1'b1;
      wbm_ack_i = 1'b1;
      for (int unsigned i = 0; i < 5; i++) begin
         @(negedge wb_clk);
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rdat_stable", rsp_rdat, held);
         chk("bp_err", 32'(rsp_err), 32'd0);
         chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("bp_no_cyc", 32'(wbm_cyc_o), 32'd0);
      end
      wbm_ack_i = 1'b0;
      rsp_ready = 1'b1;
      @(posedge wb_clk);
      #1 rsp_ready = 1'b0;
      @(negedge wb_clk);
      chk("b2b_rsp_clr", 32'(rsp_valid), 32'd0);
      chk("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("b2b_no_cyc_yet", 32'(wbm_cyc_o), 32'd0);
      @(posedge wb_clk);
      #1 cmd_valid = 1'b0;
      @(negedge wb_clk);
      chk("b2b_cyc", 32'(wbm_cyc_o), 32'd1);
      chk("b2b_adr", wbm_adr_o, 32'h3000_0080);
      chk("b2b_sel", 32'(wbm_sel_o), 32'hC);
      wbm_ack_i = 1'b1;
      @(negedge wb_clk);
      wbm_ack_i = 1'b0;
      chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("b2b_write_rdat", rsp_rdat, 32'd0);
      accept_rsp();

      // Saturating error counter over 300 timeouts.
      exp_ec = 8'd2;
      for (int unsigned i = 0; i < 300; i++) begin
         v = vecs[2];
         issue_and_wait(v);
         if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
         chk("sat_err", 32'(rsp_err), 32'd1);
         chk("sat_err_count", 32'(err_count), 32'(exp_ec));
         accept_rsp();
      end
      chk("sat_final", 32'(err_count), 32'd255);

      // Reset in stb cycle 2 of a read.
      @(negedge wb_clk);
      cmd_we    = 1'b0;
      cmd_adr   = 32'h3000_0100;
      cmd_sel   = 4'hF;
      cmd_valid = 1'b1;
      @(posedge wb_clk);
      #1 cmd_valid = 1'b0;
      @(negedge wb_clk);
      chk("mid_stb1", 32'(wbm_stb_o), 32'd1);
      @(negedge wb_clk);
      chk("mid_stb2", 32'(wbm_stb_o), 32'd1);
      wb_rst = 1'b1;
      #1;
      chk("mid_rst_cyc", 32'(wbm_cyc_o), 32'd0);
      chk("mid_rst_stb", 32'(wbm_stb_o), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_err_count", 32'(err_count), 32'd0);
      @(negedge wb_clk);
      wb_rst    = 1'b0;
      wbm_ack_i = 1'b1;
      @(posedge wb_clk);
      #1;
      chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      for (int unsigned i = 0; i < 4; i++) begin
         @(negedge wb_clk);
         chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
         chk("post_rst_no_cyc", 32'(wbm_cyc_o), 32'd0);
      end
      wbm_ack_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
